// File: rtl/proposed_multiplier.sv
// Approximate unsigned WIDTH x WIDTH multiplier: OR-combined partial-product pairs plus masked AND-error recovery.
// Latency: 2 rising edges (operand register, product register); one operand pair accepted every cycle.
// Backpressure: none; free-running pipeline, Rst asynchronously clears every stage.
module proposed_multiplier #(
  parameter int WIDTH         = 128,
  parameter int RECOVERY_BITS = 2 * WIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic [2*WIDTH-1:0]   p
);

  localparam int PW = 2 * WIDTH;

  // Pairing needs an even operand width, and the error split only makes sense from 4 bits up.
  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("proposed_multiplier: WIDTH must be even and >= 4");
  end
  if (RECOVERY_BITS < 0 || RECOVERY_BITS > PW) begin : g_bad_recovery
    $error("proposed_multiplier: RECOVERY_BITS must lie in 0..2*WIDTH");
  end

  // Columns at or above PW-RECOVERY_BITS get their AND-error added back; lower columns drop it.
  function automatic logic [PW-1:0] recovery_mask();
    logic [PW-1:0] m;
    m = '0;
    for (int b = 0; b < PW; b++) begin
      if (b >= PW - RECOVERY_BITS) begin
        m[b] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam logic [PW-1:0] MASK = recovery_mask();

  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [PW-1:0]    x_ext;
  logic [PW-1:0]    pp_lo;
  logic [PW-1:0]    pp_hi;
  logic [PW-1:0]    s_sum;
  logic [PW-1:0]    e_sum;
  logic [PW-1:0]    prod;

  assign x_ext = {{WIDTH{1'b0}}, x_q};

  // Stage 1: capture operands so the product tree sees stable inputs for a full cycle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x;
      y_q <= y;
    end
  end

  // Product tree: each pair of adjacent partial products is merged carry-free (OR),
  // and only the masked part of their overlap (AND) is fed back in; the carry-out is dropped.
  always_comb begin
    pp_lo = '0;
    pp_hi = '0;
    s_sum = '0;
    e_sum = '0;
    for (int k = 0; k < WIDTH / 2; k++) begin
      pp_lo = y_q[2*k]   ? (x_ext << (2 * k))     : '0;
      pp_hi = y_q[2*k+1] ? (x_ext << (2 * k + 1)) : '0;
      s_sum = s_sum + (pp_lo | pp_hi);
      e_sum = e_sum + (pp_lo & pp_hi & MASK);
    end
    prod = s_sum + e_sum;
  end

  // Stage 2: register the approximate product.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      p <= '0;
    end else begin
      p <= prod;
    end
  end

endmodule

// File: tb/tb_proposed_multiplier.sv
// Scoreboard bench: one default-size instance plus seventeen 8-bit instances covering every recovery depth.
// Stimulus pushes expected products tagged with the cycle they are due; a negedge monitor pops and compares.
// Reference for the 8-bit parts is exact product minus the dropped low-column pair overlaps.
module tb_proposed_multiplier;

  typedef struct packed {
    int                 due;
    logic [7:0]         x8;
    logic [7:0]         y8;
    logic [16:0][15:0]  e8;
    logic [255:0]       ew;
  } ent_t;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [7:0]    x8;
  logic [7:0]    y8;
  logic [127:0]  xw;
  logic [127:0]  yw;
  logic [255:0]  pw;
  logic [15:0]   pa [0:16];

  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  ent_t sb[$];

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  proposed_multiplier u_wide (
    .Clk (Clk),
    .Rst (Rst),
    .x   (xw),
    .y   (yw),
    .p   (pw)
  );

  for (genvar r = 0; r <= 16; r++) begin : g_r
    proposed_multiplier #(.WIDTH(8), .RECOVERY_BITS(r)) u_m (
      .Clk (Clk),
      .Rst (Rst),
      .x   (x8),
      .y   (y8),
      .p   (pa[r])
    );
  end

  // Every pair-overlap bit below column 16-r is lost; everything else adds up to the exact product.
  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input int r);
    int exact;
    int loss;
    int low;
    exact = int'(a) * int'(b);
    low   = (1 << (16 - r)) - 1;
    loss  = 0;
    for (int k = 0; k < 4; k++) begin
      if (b[2*k] && b[2*k+1]) begin
        loss += ((int'(a) << (2 * k)) & (int'(a) << (2 * k + 1))) & low;
      end
    end
    return 16'(exact - loss);
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk_le(input string name, input logic [255:0] lhs, input logic [255:0] rhs);
    tests++;
    if (!(lhs <= rhs)) begin
      fails++;
      $display("FAIL %s actual=%h required<=%h at cycle %0d", name, lhs, rhs, cyc);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_wide"}, pw, '0);
    for (int r = 0; r <= 16; r++) begin
      chk($sformatf("%s_r%0d", name, r), {240'd0, pa[r]}, '0);
    end
  endtask

  // Drive one operand set at a negedge and queue what must appear two rising edges later.
  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic [127:0] c, input logic [127:0] d);
    ent_t e;
    x8 = a;
    y8 = b;
    xw = c;
    yw = d;
    e.due = cyc + 2;
    e.x8  = a;
    e.y8  = b;
    for (int r = 0; r <= 16; r++) begin
      e.e8[r] = model8(a, b, r);
    end
    e.ew = {128'd0, c} * {128'd0, d};
    sb.push_back(e);
    @(negedge Clk);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [7:0] rand8();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0:       return 8'h00;
      1:       return 8'h01;
      2:       return 8'hFF;
      default: return 8'($urandom());
    endcase
  endfunction

  // Monitor: compare the entry due this cycle against every instance, plus ordering properties.
  always @(negedge Clk) begin
    ent_t e;
    logic [15:0] ex;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      tests++;
      fails++;
      $display("FAIL stale_entry due=%0d now=%0d", sb[0].due, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e  = sb.pop_front();
      ex = 16'(int'(e.x8) * int'(e.y8));
      chk("p_wide", pw, e.ew);
      for (int r = 0; r <= 16; r++) begin
        chk($sformatf("p_r%0d x=%h y=%h", r, e.x8, e.y8), {240'd0, pa[r]}, {240'd0, e.e8[r]});
        chk_le($sformatf("p_le_exact_r%0d", r), {240'd0, pa[r]}, {240'd0, ex});
        if (r > 0) begin
          chk_le($sformatf("p_monotonic_r%0d", r), {240'd0, pa[r-1]}, {240'd0, pa[r]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] xw0;
    logic [127:0] yw0;
    logic [255:0] wexp;
    xw0  = 128'd0 - 128'd25;
    yw0  = 128'd0 - 128'd100;
    wexp = 256'd0 - (256'd125 << 128) + 256'd2500;

    x8 = '0; y8 = '0; xw = '0; yw = '0;
    Rst = 1'b1;
    repeat (5) @(negedge Clk);
    chk_all_zero("reset_hold");
    repeat (5) @(negedge Clk);

    // Leave reset with the large directed operands; the full-recovery wide part must be exact.
    Rst = 1'b0;
    issue(8'hFF, 8'hFF, xw0, yw0);
    issue(8'hFF, 8'hFF, xw0, yw0);
    issue(8'hFF, 8'hFF, xw0, yw0);
    chk("wide_directed", pw, wexp);
    chk("ff_ff_r0",  {240'd0, pa[0]},  {240'd0, 16'hA9AB});
    chk("ff_ff_r8",  {240'd0, pa[8]},  {240'd0, 16'hFAAB});
    chk("ff_ff_r16", {240'd0, pa[16]}, {240'd0, 16'hFE01});

    issue(8'h01, 8'hB7, 128'd1, rand128());
    issue(8'h01, 8'hB7, 128'd1, rand128());
    issue(8'h01, 8'hB7, 128'd1, rand128());
    chk("x1_r0",  {240'd0, pa[0]},  {240'd0, 16'h00B7});
    chk("x1_r16", {240'd0, pa[16]}, {240'd0, 16'h00B7});
    issue(8'h00, 8'h5A, 128'd0, rand128());
    issue(8'hC3, 8'h00, rand128(), 128'd0);
    issue(8'hC3, 8'h00, rand128(), 128'd0);
    chk("zero_y_r0", {240'd0, pa[0]}, '0);
    chk("zero_wide", pw, '0);

    for (int i = 0; i < 300; i++) begin
      issue(rand8(), rand8(), rand128(), rand128());
    end

    // Async reset between edges: in-flight results vanish without a clock.
    @(posedge Clk);
    #2;
    Rst = 1'b1;
    sb.delete();
    #1;
    chk_all_zero("async_reset");
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    issue(8'hFF, 8'hFF, xw0, yw0);
    chk_all_zero("post_reset_first_edge");

    for (int i = 0; i < 200; i++) begin
      issue(rand8(), rand8(), rand128(), rand128());
    end

    repeat (4) @(negedge Clk);
    chk("scoreboard_drained", 256'(sb.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
